// File: rtl/ex_muldiv_stage_if.sv
// ex_muldiv_stage_if: pipeline-side bundle of the execute stage (ID/EX operands, forwarding taps, results).
// The master side is the pipeline that drives the instruction; the slave side is the execute stage.
interface ex_muldiv_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              valid_i;
    logic              flush_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   d1_i;
    logic [XLEN-1:0]   d2_i;
    logic [XLEN-1:0]   imm_i;
    logic [REG_AW-1:0] r1_i;
    logic [REG_AW-1:0] r2_i;
    logic [REG_AW-1:0] rd_i;
    logic [2:0]        f3_i;
    logic [6:0]        f7_i;
    logic              imm_sel_i;
    logic              pc_sel_i;
    logic              jmp_i;
    logic              br_i;
    logic              lui_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic [XLEN-1:0]   exmem_alu_i;
    logic              exmem_wr_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [XLEN-1:0]   memwb_wdata_i;
    logic              memwb_wr_i;
    logic [XLEN-1:0]   alu_o;
    logic [XLEN-1:0]   wdata_o;
    logic              br_jmp_en_o;
    logic              valid_o;
    logic              stall_o;

    modport master (
        output valid_i, flush_i, pc_i, d1_i, d2_i, imm_i, r1_i, r2_i, rd_i, f3_i, f7_i,
               imm_sel_i, pc_sel_i, jmp_i, br_i, lui_i,
               exmem_rd_i, exmem_alu_i, exmem_wr_i, memwb_rd_i, memwb_wdata_i, memwb_wr_i,
        input  alu_o, wdata_o, br_jmp_en_o, valid_o, stall_o
    );

    modport slave (
        input  valid_i, flush_i, pc_i, d1_i, d2_i, imm_i, r1_i, r2_i, rd_i, f3_i, f7_i,
               imm_sel_i, pc_sel_i, jmp_i, br_i, lui_i,
               exmem_rd_i, exmem_alu_i, exmem_wr_i, memwb_rd_i, memwb_wdata_i, memwb_wr_i,
        output alu_o, wdata_o, br_jmp_en_o, valid_o, stall_o
    );
endinterface

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: single-cycle ALU/branch execute stage with forwarding plus an iterative RV32M unit.
// Optional macro EX_DIV_EARLY_EN: divide early-out and leading-zero pre-shift (latency only, same results).
module ex_muldiv_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic clk,
    input logic rst,
    ex_muldiv_stage_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam int LW = CW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] accHi_q;
    logic [XLEN-1:0] accLo_q;
    logic [XLEN-1:0] opB_q;
    logic [XLEN-1:0] result_q;
    logic [2:0]      f3_q;
    logic            negA_q;
    logic            negB_q;
    logic            special_q;
    logic            noFix_q;

    logic [XLEN-1:0] fwdA, fwdB;
    logic [XLEN-1:0] opA, opB, aluRes;
    logic [CW-1:0]   shamt;
    logic            brCond;
    logic            isM, accept;
    logic            aSigned, bSigned, negA, negB;
    logic [XLEN-1:0] absA, absB;
    logic            divZero, divOvf;
    logic [XLEN-1:0] stepHi, stepLo;
    logic [XLEN:0]   sum, trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem, result_d;
    logic [XLEN-1:0] aluOut;
    logic            validOut, stallOut, brOut;
    logic            unusedBits;

    assign unusedBits = ^bus.rd_i;

    // EX/MEM has priority over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwdA = bus.d1_i;
        if (bus.exmem_wr_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == bus.r1_i)
            fwdA = bus.exmem_alu_i;
        else if (bus.memwb_wr_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == bus.r1_i)
            fwdA = bus.memwb_wdata_i;
        fwdB = bus.d2_i;
        if (bus.exmem_wr_i && bus.exmem_rd_i != '0 && bus.exmem_rd_i == bus.r2_i)
            fwdB = bus.exmem_alu_i;
        else if (bus.memwb_wr_i && bus.memwb_rd_i != '0 && bus.memwb_rd_i == bus.r2_i)
            fwdB = bus.memwb_wdata_i;
    end

    assign opA   = bus.pc_sel_i ? bus.pc_i : fwdA;
    assign opB   = bus.imm_sel_i ? bus.imm_i : fwdB;
    assign shamt = opB[CW-1:0];

    always_comb begin
        aluRes = '0;
        if (bus.lui_i)
            aluRes = bus.imm_i;
        else if (bus.jmp_i || bus.br_i)
            aluRes = opA + opB;
        else begin
            case (bus.f3_i)
                3'b000: aluRes = (bus.f7_i[5] && !bus.imm_sel_i) ? opA - opB : opA + opB;
                3'b001: aluRes = opA << shamt;
                3'b010: aluRes = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
                3'b011: aluRes = {{(XLEN-1){1'b0}}, opA < opB};
                3'b100: aluRes = opA ^ opB;
                3'b101: aluRes = bus.f7_i[5] ? $unsigned($signed(opA) >>> shamt) : opA >> shamt;
                3'b110: aluRes = opA | opB;
                3'b111: aluRes = opA & opB;
            endcase
        end
    end

    always_comb begin
        case (bus.f3_i)
            3'b000:  brCond = fwdA == fwdB;
            3'b001:  brCond = fwdA != fwdB;
            3'b100:  brCond = $signed(fwdA) < $signed(fwdB);
            3'b101:  brCond = $signed(fwdA) >= $signed(fwdB);
            3'b110:  brCond = fwdA < fwdB;
            3'b111:  brCond = fwdA >= fwdB;
            default: brCond = 1'b0;
        endcase
    end

    assign isM    = bus.f7_i == 7'b0000001 && !bus.imm_sel_i && !bus.jmp_i && !bus.br_i && !bus.lui_i;
    assign accept = rst && state_q == IDLE && bus.valid_i && !bus.flush_i && isM;

    // Signedness per operand: MUL/MULH/MULHSU/DIV/REM sign rs1; MUL/MULH/DIV/REM sign rs2.
    assign aSigned = bus.f3_i[2] ? !bus.f3_i[0] : (bus.f3_i[1:0] != 2'b11);
    assign bSigned = bus.f3_i[2] ? !bus.f3_i[0] : !bus.f3_i[1];
    assign negA    = aSigned && fwdA[XLEN-1];
    assign negB    = bSigned && fwdB[XLEN-1];
    assign absA    = negA ? -fwdA : fwdA;
    assign absB    = negB ? -fwdB : fwdB;
    assign divZero = bus.f3_i[2] && fwdB == '0;
    assign divOvf  = bus.f3_i[2] && !bus.f3_i[0] && fwdA == {1'b1, {(XLEN-1){1'b0}}} && fwdB == '1;

`ifdef EX_DIV_EARLY_EN
    logic          divEarly;
    logic [LW-1:0] lz;

    function automatic logic [LW-1:0] lzc(input logic [XLEN-1:0] v);
        logic [LW-1:0] n;
        n = LW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (v[i]) n = LW'(XLEN - 1 - i);
        return n;
    endfunction

    assign divEarly = bus.f3_i[2] && absA < absB;
    assign lz       = lzc(absA);
`endif

    // Remainder is shifted into XLEN+1 bits so a full-width divisor never overflows the trial subtract.
    always_comb begin
        stepHi = accHi_q;
        stepLo = accLo_q;
        sum    = '0;
        trial  = '0;
        if (!special_q) begin
            if (f3_q[2]) begin
                trial = {accHi_q, accLo_q[XLEN-1]} - {1'b0, opB_q};
                if (!trial[XLEN]) begin
                    stepHi = trial[XLEN-1:0];
                    stepLo = {accLo_q[XLEN-2:0], 1'b1};
                end else begin
                    stepHi = {accHi_q[XLEN-2:0], accLo_q[XLEN-1]};
                    stepLo = {accLo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                sum    = {1'b0, accHi_q} + ({1'b0, opB_q} & {(XLEN+1){accLo_q[0]}});
                stepHi = sum[XLEN:1];
                stepLo = {sum[0], accLo_q[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = {stepHi, stepLo};
        if (negA_q ^ negB_q)
            prod = -prod;
        quo = (negA_q ^ negB_q) ? -stepLo : stepLo;
        rem = negA_q ? -stepHi : stepHi;
        if (noFix_q)
            result_d = f3_q[1] ? stepHi : stepLo;
        else if (f3_q[2])
            result_d = f3_q[1] ? rem : quo;
        else
            result_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            result_q  <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            opB_q     <= '0;
            f3_q      <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            special_q <= 1'b0;
            noFix_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= BUSY;
                        f3_q      <= bus.f3_i;
                        negA_q    <= negA;
                        negB_q    <= negB;
                        opB_q     <= absB;
                        count_q   <= CW'(XLEN - 1);
                        accHi_q   <= '0;
                        accLo_q   <= absA;
                        special_q <= 1'b0;
                        noFix_q   <= 1'b0;
                        if (divZero) begin
                            accHi_q   <= fwdA;
                            accLo_q   <= '1;
                            special_q <= 1'b1;
                            noFix_q   <= 1'b1;
                        end else if (divOvf) begin
                            accHi_q   <= '0;
                            accLo_q   <= fwdA;
                            special_q <= 1'b1;
                            noFix_q   <= 1'b1;
                        end
`ifdef EX_DIV_EARLY_EN
                        else if (divEarly) begin
                            accHi_q   <= absA;
                            accLo_q   <= '0;
                            special_q <= 1'b1;
                        end else if (bus.f3_i[2]) begin
                            accLo_q <= absA << lz;
                            count_q <= CW'(XLEN - 1 - int'(lz));
                        end
`endif
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                    end else if (special_q || count_q == '0) begin
                        accHi_q  <= stepHi;
                        accLo_q  <= stepLo;
                        result_q <= result_d;
                        state_q  <= DONE;
                    end else begin
                        accHi_q <= stepHi;
                        accLo_q <= stepLo;
                        count_q <= count_q - 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        aluOut   = aluRes;
        validOut = 1'b0;
        stallOut = 1'b0;
        brOut    = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    validOut = bus.valid_i && !bus.flush_i && !isM;
                    stallOut = accept;
                    brOut    = bus.valid_i && !bus.flush_i && ((bus.br_i && brCond) || bus.jmp_i);
                end
                BUSY: stallOut = 1'b1;
                DONE: begin
                    aluOut   = result_q;
                    validOut = !bus.flush_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_o       = aluOut;
    assign bus.wdata_o     = fwdB;
    assign bus.valid_o     = validOut;
    assign bus.stall_o     = stallOut;
    assign bus.br_jmp_en_o = brOut;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage: directed self-checking bench for ex_muldiv_stage.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_ex_muldiv_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    localparam logic [6:0] F7_M      = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    int   passCnt  = 0;
    int   failCnt  = 0;
    int   checkCnt = 0;
    int   stalls;

    ex_muldiv_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    ex_muldiv_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives one instruction with operands from the register file and no forwarding hits.
    task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic immSel, input logic pcSel, input logic br,
                                 input logic jmp, input logic lui,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        bus.valid_i       = 1'b1;
        bus.flush_i       = 1'b0;
        bus.pc_i          = pc;
        bus.d1_i          = a;
        bus.d2_i          = b;
        bus.imm_i         = imm;
        bus.r1_i          = 5'd1;
        bus.r2_i          = 5'd2;
        bus.rd_i          = 5'd7;
        bus.f3_i          = f3;
        bus.f7_i          = f7;
        bus.imm_sel_i     = immSel;
        bus.pc_sel_i      = pcSel;
        bus.jmp_i         = jmp;
        bus.br_i          = br;
        bus.lui_i         = lui;
        bus.exmem_rd_i    = 5'd0;
        bus.exmem_alu_i   = '0;
        bus.exmem_wr_i    = 1'b0;
        bus.memwb_rd_i    = 5'd0;
        bus.memwb_wdata_i = '0;
        bus.memwb_wr_i    = 1'b0;
    endtask

    // Issues an M op, counts stall cycles (bounded) and checks the result cycle.
    task automatic runM(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, output int nStall);
        @(negedge clk);
        applyStimulus(f3, F7_M, a, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        nStall = 0;
        while (bus.stall_o === 1'b1 && nStall < 100) begin
            nStall++;
            @(negedge clk);
            #1;
        end
        checkBit({tag, "_valid"}, bus.valid_o, 1'b1);
        checkOutput({tag, "_result"}, bus.alu_o, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(F3_MUL, F7_M, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk); #1;
        checkBit("rst_stall", bus.stall_o, 1'b0);
        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h8);
        #1;
        checkBit("rst_valid", bus.valid_o, 1'b0);
        checkBit("rst_brjmp", bus.br_jmp_en_o, 1'b0);

        // ADD: x5 hits both EX/MEM and MEM/WB; EX/MEM wins
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(3'b000, 7'd0, 32'h99, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        bus.r1_i = 5'd5; bus.r2_i = 5'd6;
        bus.exmem_rd_i = 5'd5; bus.exmem_alu_i = 32'h11; bus.exmem_wr_i = 1'b1;
        bus.memwb_rd_i = 5'd5; bus.memwb_wdata_i = 32'h22; bus.memwb_wr_i = 1'b1;
        #1;
        checkOutput("add_fwd_exmem", bus.alu_o, 32'h12);
        checkBit("add_valid", bus.valid_o, 1'b1);
        checkBit("add_stall", bus.stall_o, 1'b0);

        // rd = x0 in EX/MEM must not forward
        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        bus.r1_i = 5'd0;
        bus.exmem_rd_i = 5'd0; bus.exmem_alu_i = 32'h11; bus.exmem_wr_i = 1'b1;
        #1;
        checkOutput("add_x0_nofwd", bus.alu_o, 32'h1);

        // r1 from EX/MEM and r2 from MEM/WB at once
        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'hDEAD, 32'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        bus.r1_i = 5'd3; bus.r2_i = 5'd4;
        bus.exmem_rd_i = 5'd3; bus.exmem_alu_i = 32'h100; bus.exmem_wr_i = 1'b1;
        bus.memwb_rd_i = 5'd4; bus.memwb_wdata_i = 32'h23; bus.memwb_wr_i = 1'b1;
        #1;
        checkOutput("add_dual_fwd", bus.alu_o, 32'h123);
        checkOutput("wdata_fwd", bus.wdata_o, 32'h23);
        bus.f7_i = 7'b0100000;
        #1;
        checkOutput("sub_dual_fwd", bus.alu_o, 32'hDD);

        // Branches with rs1 = -3, rs2 = 2, target pc + imm
        @(negedge clk);
        applyStimulus(3'b100, 7'd0, 32'hFFFF_FFFD, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h40);
        #1;
        checkBit("blt_taken", bus.br_jmp_en_o, 1'b1);
        checkOutput("blt_target", bus.alu_o, 32'h1040);
        bus.f3_i = 3'b101;
        #1;
        checkBit("bge_not_taken", bus.br_jmp_en_o, 1'b0);
        bus.f3_i = 3'b110;
        #1;
        checkBit("bltu_not_taken", bus.br_jmp_en_o, 1'b0);

        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h10);
        #1;
        checkBit("jal_en", bus.br_jmp_en_o, 1'b1);
        checkOutput("jal_target", bus.alu_o, 32'h2010);

        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 32'hABCD_E000);
        #1;
        checkOutput("lui", bus.alu_o, 32'hABCD_E000);

        // Multiply family
        runM("mul", F3_MUL, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, stalls);
        checkOutput("mul_stalls", XLEN'(stalls), 32'd33);
        runM("mulh", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, stalls);
        runM("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, stalls);
        runM("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, stalls);

        // Divide family including decoded special cases
        runM("div_by_zero", F3_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, stalls);
        checkOutput("div_by_zero_stalls", XLEN'(stalls), 32'd2);
        runM("rem_by_zero", F3_REM, 32'd7, 32'd0, 32'd7, stalls);
        checkOutput("rem_by_zero_stalls", XLEN'(stalls), 32'd2);
        runM("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, stalls);
        checkOutput("div_ovf_stalls", XLEN'(stalls), 32'd2);
        runM("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, stalls);
        runM("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, stalls);
        runM("remu", F3_REMU, 32'd100, 32'd7, 32'd2, stalls);
        runM("div_neg", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, stalls);
        runM("rem_neg", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, stalls);

        // Flush in the tenth BUSY cycle of a full-length divide
        @(negedge clk);
        applyStimulus(F3_DIVU, F7_M, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checkBit("flush_accept_stall", bus.stall_o, 1'b1);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        checkBit("flush_stall_low", bus.stall_o, 1'b0);
        checkBit("flush_no_valid", bus.valid_o, 1'b0);
        @(negedge clk);
        applyStimulus(3'b000, 7'd0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checkBit("post_flush_add_valid", bus.valid_o, 1'b1);
        checkOutput("post_flush_add", bus.alu_o, 32'd11);

        // Reset in the middle of a multiply
        @(negedge clk);
        applyStimulus(F3_MUL, F7_M, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checkBit("midrst_stall", bus.stall_o, 1'b0);
        checkBit("midrst_valid", bus.valid_o, 1'b0);
        checkBit("midrst_brjmp", bus.br_jmp_en_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.valid_i = 1'b0;
        #1;
        checkBit("after_rst_idle", bus.stall_o, 1'b0);
        runM("mul_after_rst", F3_MUL, 32'd3, 32'd5, 32'd15, stalls);
        checkOutput("mul_after_rst_stalls", XLEN'(stalls), 32'd33);

        @(negedge clk);
        bus.valid_i = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
